afe_sensor_model: RTL and testbench

Synthesizable model of the pulse-oximeter analog front end (photodiode, DC compensation, PGA and 8-bit ADC). It sits on the opposite side of the controller's sensor interface: it consumes the controller's `LED_IR`/`LED_RED`, `LED_DRIVE`, `DC_Comp`, `PGA_Gain` and `CLK_Filter` outputs and returns the `ADC` code. A built-in pulsatile waveform lets the controller's settings search and IR/RED capture run closed-loop in simulation and on FPGA.

---
 rtl/afe_sensor_model.sv | 93 +++++++++
 tb/tb_afe_sensor_model.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/afe_sensor_model.sv
// afe_sensor_model: pulse-oximeter analog front end model (photodiode, DC compensation, PGA, 8-bit ADC)
//
// Ports:
//   CLK        system clock
//   rst        asynchronous, active-high reset
//   LED_IR     IR LED on
//   LED_RED    RED LED on
//   LED_DRIVE  LED current code, linear multiplier 0..15
//   DC_Comp    DC offset subtraction code, 8 photo units per LSB
//   PGA_Gain   gain code, gain = PGA_Gain + 1
//   CLK_Filter sample strobe, converts on its rising edge
//   ADC        last converted code
//   settled    high while the analog path is settled
module afe_sensor_model #(
   parameter logic [7:0]  IR_BASE      = 8'd40,
   parameter logic [7:0]  RED_BASE     = 8'd30,
   parameter logic [3:0]  PULSE_AMP    = 4'd4,
   parameter int unsigned PULSE_PERIOD = 1000,
   parameter int unsigned SETTLE       = 3
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       LED_IR,
   input  logic       LED_RED,
   input  logic [3:0] LED_DRIVE,
   input  logic [6:0] DC_Comp,
   input  logic [3:0] PGA_Gain,
   input  logic       CLK_Filter,
   output logic [7:0] ADC,
   output logic       settled
);
   typedef enum logic {S_SETTLE, S_VALID} state_t;
   localparam logic [9:0] PH_LAST  = 10'(PULSE_PERIOD - 1);
   localparam logic [9:0] PH_HALF  = 10'(PULSE_PERIOD / 2);
   localparam logic [3:0] CNT_INIT = 4'(SETTLE);
   logic [9:0]  phase;
   logic [3:0]  p;
   logic [7:0]  base;
   logic        dark;
   logic [12:0] photo;
   logic [12:0] comp;
   logic [12:0] diff;
   logic [17:0] amp;
   logic [7:0]  code;
   logic [7:0]  code_q;
   logic [16:0] cfg;
   logic [16:0] cfg_q;
   logic        chg;
   logic        cf_q;
   logic        rise;
   logic [3:0]  cnt;
   state_t      state;
   always_comb begin
      p     = (phase < PH_HALF) ? PULSE_AMP : 4'd0;
      base  = LED_IR ? IR_BASE : RED_BASE;
      // both LEDs on is treated as dark, same as both off
      dark  = LED_IR == LED_RED;
      photo = dark ? 13'd0 : (13'(base) + 13'(p)) * 13'(LED_DRIVE);
      comp  = 13'({DC_Comp, 3'b000});
      diff  = (photo > comp) ? photo - comp : 13'd0;
      amp   = 18'(diff) * 18'({1'b0, PGA_Gain} + 5'd1);
      code  = (amp > 18'd255) ? 8'hff : amp[7:0];
      cfg   = {LED_IR, LED_RED, LED_DRIVE, DC_Comp, PGA_Gain};
      chg   = cfg != cfg_q;
      rise  = CLK_Filter & ~cf_q;
   end
   assign settled = state == S_VALID;
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         phase  <= 10'd0;
         code_q <= 8'd0;
         cf_q   <= 1'b0;
         cfg_q  <= 17'd0;
         cnt    <= CNT_INIT;
         state  <= S_SETTLE;
         ADC    <= 8'd0;
      end else begin
         phase  <= (phase == PH_LAST) ? 10'd0 : phase + 10'd1;
         code_q <= code;
         cf_q   <= CLK_Filter;
         if (chg) begin
            cfg_q <= cfg;
            cnt   <= CNT_INIT;
            state <= S_SETTLE;
         end else if (state == S_SETTLE) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= S_VALID;
         end
         // a strobe during settling or coinciding with a setting change is dropped
         if (rise && state == S_VALID && !chg) ADC <= code_q;
      end
   end
endmodule

// File: tb/tb_afe_sensor_model.sv
// tb_afe_sensor_model: table-driven and directed checks of afe_sensor_model
module tb_afe_sensor_model;
   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic       LED_IR = 1'b0;
   logic       LED_RED = 1'b0;
   logic [3:0] LED_DRIVE = 4'd0;
   logic [6:0] DC_Comp = 7'd0;
   logic [3:0] PGA_Gain = 4'd0;
   logic       CLK_Filter = 1'b0;
   logic [7:0] ADC;
   logic       settled;
   int n_cmp = 0;
   int n_bad = 0;
   int tb_phase;
   typedef struct {
      logic       ir;
      logic       red;
      logic [3:0] drv;
      logic [6:0] dc;
      logic [3:0] gain;
      logic       sys;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs[14];
   afe_sensor_model dut (
      .CLK(CLK), .rst(rst), .LED_IR(LED_IR), .LED_RED(LED_RED), .LED_DRIVE(LED_DRIVE),
      .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain), .CLK_Filter(CLK_Filter), .ADC(ADC), .settled(settled)
   );
   always #5 CLK = ~CLK;
   always @(posedge CLK or posedge rst)
      if (rst) tb_phase <= 0;
      else tb_phase <= (tb_phase == 999) ? 0 : tb_phase + 1;
   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask
   task automatic set_cfg(input logic ir, input logic red, input logic [3:0] drv, input logic [6:0] dc, input logic [3:0] gain);
      @(negedge CLK);
      LED_IR = ir;
      LED_RED = red;
      LED_DRIVE = drv;
      DC_Comp = dc;
      PGA_Gain = gain;
   endtask
   task automatic wait_half(input logic sys);
      int lo;
      int hi;
      bit ok;
      lo = sys ? 20 : 520;
      hi = sys ? 300 : 800;
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge CLK);
         ok = tb_phase >= lo && tb_phase <= hi;
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_half: phase window %0d..%0d not reached", lo, hi);
      end
   endtask
   task automatic strobe(input string nm, input logic [7:0] exp);
      @(negedge CLK);
      CLK_Filter = 1'b1;
      @(negedge CLK);
      check(nm, ADC, exp);
      CLK_Filter = 1'b0;
   endtask
   initial begin
      vecs[0]  = '{1'b1, 1'b0, 4'd2,  7'd5,   4'd1,  1'b1, 8'd96};
      vecs[1]  = '{1'b1, 1'b0, 4'd2,  7'd5,   4'd1,  1'b0, 8'd80};
      vecs[2]  = '{1'b0, 1'b1, 4'd2,  7'd5,   4'd1,  1'b1, 8'd56};
      vecs[3]  = '{1'b0, 1'b1, 4'd2,  7'd5,   4'd1,  1'b0, 8'd40};
      vecs[4]  = '{1'b1, 1'b1, 4'd2,  7'd5,   4'd1,  1'b1, 8'd0};
      vecs[5]  = '{1'b0, 1'b0, 4'd2,  7'd5,   4'd1,  1'b1, 8'd0};
      vecs[6]  = '{1'b1, 1'b0, 4'd15, 7'd0,   4'd15, 1'b1, 8'd255};
      vecs[7]  = '{1'b1, 1'b0, 4'd2,  7'd127, 4'd1,  1'b1, 8'd0};
      vecs[8]  = '{1'b1, 1'b0, 4'd2,  7'd5,   4'd3,  1'b1, 8'd192};
      vecs[9]  = '{1'b1, 1'b0, 4'd2,  7'd5,   4'd3,  1'b0, 8'd160};
      vecs[10] = '{1'b1, 1'b0, 4'd1,  7'd0,   4'd0,  1'b1, 8'd44};
      vecs[11] = '{1'b1, 1'b0, 4'd1,  7'd0,   4'd0,  1'b0, 8'd40};
      vecs[12] = '{1'b0, 1'b1, 4'd3,  7'd10,  4'd2,  1'b1, 8'd66};
      vecs[13] = '{1'b0, 1'b1, 4'd3,  7'd10,  4'd2,  1'b0, 8'd30};
      #1;
      check("reset_adc", ADC, 8'd0);
      check("reset_settled", settled, 1'b0);
      repeat (2) @(negedge CLK);
      rst = 1'b0;
      repeat (2) @(negedge CLK);
      check("post_reset_settle_2", settled, 1'b0);
      @(negedge CLK);
      check("post_reset_settle_3", settled, 1'b1);
      for (int i = 0; i < 14; i++) begin
         set_cfg(vecs[i].ir, vecs[i].red, vecs[i].drv, vecs[i].dc, vecs[i].gain);
         repeat (4) @(negedge CLK);
         check($sformatf("vec%0d_settled", i), settled, 1'b1);
         wait_half(vecs[i].sys);
         strobe($sformatf("vec%0d_adc", i), vecs[i].exp);
      end
      set_cfg(1'b1, 1'b0, 4'd2, 7'd5, 4'd1);
      @(negedge CLK);
      check("settle_edge1", settled, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      check("settle_edge2", settled, 1'b0);
      @(negedge CLK);
      check("settle_edge3", settled, 1'b1);
      wait_half(1'b1);
      strobe("gain1_base", 8'd96);
      set_cfg(1'b1, 1'b0, 4'd2, 7'd5, 4'd3);
      strobe("rise_1_after_change", 8'd96);
      repeat (3) @(negedge CLK);
      strobe("gain3_after_settle", 8'd192);
      set_cfg(1'b1, 1'b0, 4'd2, 7'd5, 4'd1);
      @(negedge CLK);
      strobe("rise_2_after_change", 8'd192);
      repeat (3) @(negedge CLK);
      strobe("gain1_after_settle", 8'd96);
      wait_half(1'b1);
      set_cfg(1'b1, 1'b0, 4'd2, 7'd5, 4'd3);
      repeat (4) @(negedge CLK);
      @(negedge CLK);
      CLK_Filter = 1'b1;
      @(negedge CLK);
      check("held_first_conv", ADC, 8'd192);
      repeat (10) @(negedge CLK);
      PGA_Gain = 4'd1;
      repeat (39) @(negedge CLK);
      check("held_no_reconv", ADC, 8'd192);
      CLK_Filter = 1'b0;
      strobe("after_held_release", 8'd96);
      wait_half(1'b1);
      @(negedge CLK);
      PGA_Gain = 4'd3;
      CLK_Filter = 1'b1;
      @(negedge CLK);
      check("rise_with_change_adc", ADC, 8'd96);
      check("rise_with_change_settled", settled, 1'b0);
      CLK_Filter = 1'b0;
      repeat (4) @(negedge CLK);
      strobe("after_change_rise", 8'd192);
      @(negedge CLK);
      #2 rst = 1'b1;
      #1;
      check("rst_valid_adc", ADC, 8'd0);
      check("rst_valid_settled", settled, 1'b0);
      @(negedge CLK);
      rst = 1'b0;
      strobe("rise_during_resettle", 8'd0);
      repeat (3) @(negedge CLK);
      check("resettled", settled, 1'b1);
      strobe("first_conv_after_rst", 8'd192);
      set_cfg(1'b1, 1'b0, 4'd2, 7'd5, 4'd1);
      @(negedge CLK);
      #2 rst = 1'b1;
      #1;
      check("rst_settle_adc", ADC, 8'd0);
      check("rst_settle_settled", settled, 1'b0);
      @(negedge CLK);
      rst = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_settle_still_settling", settled, 1'b0);
      @(negedge CLK);
      check("rst_settle_done", settled, 1'b1);
      strobe("rst_settle_conv", 8'd96);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
